// File: rtl/tx_sched_pkg.sv
// Shared state encoding and header layout for the two-source tx frame scheduler.
package tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      STREAM,
      DONE
   } state_e;

   localparam int HDR_W        = 40;
   localparam int HDR_SYNC_LSB = 32;
   localparam int HDR_SRC_BIT  = 31;
   localparam int HDR_SEQ_LSB  = 0;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // Header word: {sync[7:0], src, 15'b0, seq[15:0]}
   function automatic logic [HDR_W-1:0] build_header(input logic [7:0]  sync,
                                                     input logic        src,
                                                     input logic [15:0] seq);
      logic [HDR_W-1:0] hdr;
      hdr                      = '0;
      hdr[HDR_SYNC_LSB +: 8]   = sync;
      hdr[HDR_SRC_BIT]         = src;
      hdr[HDR_SEQ_LSB +: 16]   = seq;
      return hdr;
   endfunction

endpackage

// File: rtl/tx_frame_sched_rr_arb2.sv
// Two-way round-robin arbiter: the pointer source wins when it requests,
// otherwise the other source is granted.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   always_comb begin
      gnt_valid = |req;
      gnt_idx   = req[ptr] ? ptr : ~ptr;
   end

endmodule

// File: rtl/tx_frame_sched.sv
// Round-robin frame scheduler sharing the tx datapath between two sample FIFOs;
// each granted burst is a header word followed by BURST_LEN payload words.
module tx_frame_sched
   import tx_sched_pkg::*;
#(
   parameter int         DW        = 40,
   parameter int         BURST_LEN = 256,
   parameter logic [7:0] SYNC      = SYNC_DEFAULT
) (
   input  logic          clk125,
   input  logic          reset,
   input  logic          enable,
   input  logic          src0_afull,
   output logic          src0_rden,
   input  logic [DW-1:0] src0_q,
   input  logic          src1_afull,
   output logic          src1_rden,
   input  logic [DW-1:0] src1_q,
   output logic          tx_full,
   input  logic          tx_rden,
   output logic [DW-1:0] tx_data,
   output logic          grant_src,
   output logic          busy,
   output logic          overrun,
   output logic [15:0]   seq
);

   localparam int            CW       = $clog2(BURST_LEN + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);
   localparam logic [CW-1:0] BURST_CW = CW'(BURST_LEN);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            gsrc_q, gsrc_d;
   logic            ptr_q, ptr_d;
   logic [15:0]     seq_q, seq_d;
   logic            ovr_q, ovr_d;
   logic            pay_vld_q, pay_vld_d;
   logic [DW-1:0]   hold_q, hold_d;

   logic            arb_vld;
   logic            arb_idx;
   logic            pay_rd;
   logic [DW-1:0]   gsrc_data;

   rr_arb2 u_arb (
      .req       ({src1_afull, src0_afull}),
      .ptr       (ptr_q),
      .gnt_valid (arb_vld),
      .gnt_idx   (arb_idx)
   );

   assign gsrc_data = gsrc_q ? src1_q : src0_q;

   // A payload FIFO read happens only in STREAM with words still owed; reset
   // suppresses it so an aborted frame does not pop a word nobody will use.
   assign pay_rd = tx_rden && !reset && (state_q == STREAM) && (cnt_q < BURST_CW);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gsrc_d    = gsrc_q;
      ptr_d     = ptr_q;
      seq_d     = seq_q;
      ovr_d     = ovr_q;
      pay_vld_d = pay_rd;
      hold_d    = pay_vld_q ? gsrc_data : hold_q;

      unique case (state_q)
         IDLE: begin
            if (tx_rden) begin
               ovr_d = 1'b1;
            end
            if (enable && arb_vld) begin
               gsrc_d  = arb_idx;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (tx_rden) begin
               hold_d  = DW'(build_header(SYNC, gsrc_q, seq_q));
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (pay_rd) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_IDX) begin
                  state_d = DONE;
               end
            end else if (tx_rden) begin
               ovr_d = 1'b1;
            end
         end
         DONE: begin
            if (tx_rden) begin
               ovr_d = 1'b1;
            end
            seq_d   = seq_q + 16'd1;
            ptr_d   = ~gsrc_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk125) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         gsrc_q    <= 1'b0;
         ptr_q     <= 1'b0;
         seq_q     <= '0;
         ovr_q     <= 1'b0;
         pay_vld_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gsrc_q    <= gsrc_d;
         ptr_q     <= ptr_d;
         seq_q     <= seq_d;
         ovr_q     <= ovr_d;
         pay_vld_q <= pay_vld_d;
         hold_q    <= hold_d;
      end
   end

   // Payload words come straight from the FIFO Q in the cycle after the read;
   // the hold register keeps the last shown word when no read is in flight.
   assign tx_data   = pay_vld_q ? gsrc_data : hold_q;
   assign src0_rden = pay_rd && !gsrc_q;
   assign src1_rden = pay_rd &&  gsrc_q;
   assign tx_full   = (state_q == GRANT) || (state_q == STREAM);
   assign busy      = (state_q == GRANT) || (state_q == STREAM);
   assign grant_src = gsrc_q;
   assign overrun   = ovr_q;
   assign seq       = seq_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched with a 4-word burst and two counting FIFO models.
module tb_tx_frame_sched;

   localparam int         DW        = 40;
   localparam int         BURST_LEN = 4;
   localparam logic [7:0] SYNC      = 8'hA5;

   logic          clk125 = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          src0_afull = 1'b0;
   logic          src1_afull = 1'b0;
   logic          src0_rden, src1_rden;
   logic [DW-1:0] src0_q = '0;
   logic [DW-1:0] src1_q = '0;
   logic          tx_full;
   logic          tx_rden = 1'b0;
   logic [DW-1:0] tx_data;
   logic          grant_src, busy, overrun;
   logic [15:0]   seq;

   int total = 0;
   int bad   = 0;
   int rd0_cnt = 0;
   int rd1_cnt = 0;

   tx_frame_sched #(.DW(DW), .BURST_LEN(BURST_LEN), .SYNC(SYNC)) dut (
      .clk125     (clk125),
      .reset      (reset),
      .enable     (enable),
      .src0_afull (src0_afull),
      .src0_rden  (src0_rden),
      .src0_q     (src0_q),
      .src1_afull (src1_afull),
      .src1_rden  (src1_rden),
      .src1_q     (src1_q),
      .tx_full    (tx_full),
      .tx_rden    (tx_rden),
      .tx_data    (tx_data),
      .grant_src  (grant_src),
      .busy       (busy),
      .overrun    (overrun),
      .seq        (seq)
   );

   always #4 clk125 = ~clk125;

   // FIFO models: Q shows {tag, read index} one cycle after each read.
   always @(posedge clk125) begin
      if (src0_rden) begin
         src0_q  <= {8'h0A, 32'(rd0_cnt)};
         rd0_cnt <= rd0_cnt + 1;
      end
      if (src1_rden) begin
         src1_q  <= {8'h0B, 32'(rd1_cnt)};
         rd1_cnt <= rd1_cnt + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk125);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      enable     = 1'b0;
      tx_rden    = 1'b0;
      src0_afull = 1'b0;
      src1_afull = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pull_frame(input logic esrc, input logic [15:0] eseq, input bit gaps);
      int            base;
      int            waits;
      logic [DW-1:0] exp_w;
      base  = esrc ? rd1_cnt : rd0_cnt;
      waits = 0;
      while (tx_full !== 1'b1 && waits < 10) begin
         tick();
         waits++;
      end
      total++; if (tx_full !== 1'b1) begin bad++; $display("FAIL grant_wait tx_full=%b want=1", tx_full); return; end
      total++; if (grant_src !== esrc) begin bad++; $display("FAIL grant_src got=%b want=%b", grant_src, esrc); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_grant got=%b want=1", busy); end
      tx_rden = 1'b1;
      #1;
      total++; if ({src1_rden, src0_rden} !== 2'b00) begin bad++; $display("FAIL hdr_no_read rden=%b want=00", {src1_rden, src0_rden}); end
      tick();
      tx_rden = 1'b0;
      exp_w = {SYNC, esrc, 15'b0, eseq};
      total++; if (tx_data !== exp_w) begin bad++; $display("FAIL header got=%h want=%h", tx_data, exp_w); end
      for (int j = 0; j < BURST_LEN; j++) begin
         if (gaps) begin
            tick();
            total++; if (tx_data !== exp_w) begin bad++; $display("FAIL gap_hold got=%h want=%h", tx_data, exp_w); end
         end
         tx_rden = 1'b1;
         #1;
         total++; if ({src1_rden, src0_rden} !== (esrc ? 2'b10 : 2'b01)) begin bad++; $display("FAIL pay_rden w%0d got=%b want=%b", j, {src1_rden, src0_rden}, (esrc ? 2'b10 : 2'b01)); end
         tick();
         tx_rden = 1'b0;
         exp_w = {(esrc ? 8'h0B : 8'h0A), 32'(base + j)};
         total++; if (tx_data !== exp_w) begin bad++; $display("FAIL payload w%0d got=%h want=%h", j, tx_data, exp_w); end
      end
      total++; if (tx_full !== 1'b0) begin bad++; $display("FAIL full_drop got=%b want=0", tx_full); end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if ({tx_full, busy, overrun, grant_src} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {tx_full, busy, overrun, grant_src}); end
      total++; if (seq !== 16'd0) begin bad++; $display("FAIL reset_seq got=%h want=0000", seq); end
      total++; if (tx_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", tx_data); end
      total++; if ({src1_rden, src0_rden} !== 2'b00) begin bad++; $display("FAIL reset_rden got=%b want=00", {src1_rden, src0_rden}); end
   endtask

   task automatic test_basic();
      int s0, s1;
      do_reset();
      s0 = rd0_cnt;
      s1 = rd1_cnt;
      enable     = 1'b1;
      src0_afull = 1'b1;
      pull_frame(1'b0, 16'd0, 1'b0);
      src0_afull = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%b want=0", busy); end
      tick();
      total++; if (seq !== 16'd1) begin bad++; $display("FAIL basic_seq got=%0d want=1", seq); end
      total++; if (rd0_cnt - s0 !== 4) begin bad++; $display("FAIL basic_rd0_count got=%0d want=4", rd0_cnt - s0); end
      total++; if (rd1_cnt - s1 !== 0) begin bad++; $display("FAIL basic_rd1_count got=%0d want=0", rd1_cnt - s1); end
      total++; if (tx_data !== {8'h0A, 32'(s0 + 3)}) begin bad++; $display("FAIL basic_hold got=%h want=%h", tx_data, {8'h0A, 32'(s0 + 3)}); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%b want=0", overrun); end
   endtask

   task automatic test_round_robin();
      do_reset();
      enable     = 1'b1;
      src0_afull = 1'b1;
      src1_afull = 1'b1;
      pull_frame(1'b0, 16'd0, 1'b0);
      pull_frame(1'b1, 16'd1, 1'b0);
      pull_frame(1'b0, 16'd2, 1'b0);
      src0_afull = 1'b0;
      src1_afull = 1'b0;
      tick();
      total++; if (seq !== 16'd3) begin bad++; $display("FAIL rr_seq got=%0d want=3", seq); end
   endtask

   task automatic test_gaps();
      do_reset();
      enable     = 1'b1;
      src0_afull = 1'b1;
      pull_frame(1'b0, 16'd0, 1'b1);
      src0_afull = 1'b0;
      tick();
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL gaps_overrun got=%b want=0", overrun); end
      total++; if (seq !== 16'd1) begin bad++; $display("FAIL gaps_seq got=%0d want=1", seq); end
   endtask

   task automatic test_overrun();
      int            s0;
      logic [DW-1:0] last;
      do_reset();
      tx_rden = 1'b1;
      tick();
      tx_rden = 1'b0;
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_idle got=%b want=1", overrun); end
      do_reset();
      enable     = 1'b1;
      src0_afull = 1'b1;
      pull_frame(1'b0, 16'd0, 1'b0);
      src0_afull = 1'b0;
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clean_frame got=%b want=0", overrun); end
      s0   = rd0_cnt;
      last = tx_data;
      tx_rden = 1'b1;
      #1;
      total++; if (src0_rden !== 1'b0) begin bad++; $display("FAIL ovr_extra_rden got=%b want=0", src0_rden); end
      tick();
      tx_rden = 1'b0;
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_extra got=%b want=1", overrun); end
      total++; if (tx_data !== last) begin bad++; $display("FAIL ovr_data got=%h want=%h", tx_data, last); end
      tx_rden = 1'b1;
      tick();
      tx_rden = 1'b0;
      tick();
      tick();
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
      total++; if (rd0_cnt !== s0) begin bad++; $display("FAIL ovr_no_read got=%0d want=%0d", rd0_cnt, s0); end
      total++; if (tx_data !== last) begin bad++; $display("FAIL ovr_data_idle got=%h want=%h", tx_data, last); end
   endtask

   task automatic test_reset_mid_frame();
      int waits;
      do_reset();
      enable     = 1'b1;
      src0_afull = 1'b1;
      src1_afull = 1'b1;
      pull_frame(1'b0, 16'd0, 1'b0);
      waits = 0;
      while (tx_full !== 1'b1 && waits < 10) begin
         tick();
         waits++;
      end
      total++; if (grant_src !== 1'b1 || tx_full !== 1'b1) begin bad++; $display("FAIL rst_second_grant src=%b full=%b want=1 1", grant_src, tx_full); end
      tx_rden = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      tx_rden = 1'b0;
      total++; if ({tx_full, busy, overrun, grant_src} !== 4'b0000) begin bad++; $display("FAIL rst_mid_flags got=%b want=0000", {tx_full, busy, overrun, grant_src}); end
      total++; if (seq !== 16'd0) begin bad++; $display("FAIL rst_mid_seq got=%h want=0000", seq); end
      total++; if (tx_data !== '0) begin bad++; $display("FAIL rst_mid_data got=%h want=0", tx_data); end
      total++; if ({src1_rden, src0_rden} !== 2'b00) begin bad++; $display("FAIL rst_mid_rden got=%b want=00", {src1_rden, src0_rden}); end
      pull_frame(1'b0, 16'd0, 1'b0);
      src0_afull = 1'b0;
      src1_afull = 1'b0;
      tick();
   endtask

   task automatic test_seq_wrap();
      do_reset();
      force dut.seq_q = 16'hFFFF;
      enable     = 1'b1;
      src0_afull = 1'b1;
      tick();
      release dut.seq_q;
      pull_frame(1'b0, 16'hFFFF, 1'b0);
      src0_afull = 1'b0;
      tick();
      total++; if (seq !== 16'h0000) begin bad++; $display("FAIL seq_wrap got=%h want=0000", seq); end
   endtask

   task automatic test_enable();
      do_reset();
      src0_afull = 1'b1;
      src1_afull = 1'b1;
      repeat (6) tick();
      total++; if (tx_full !== 1'b0) begin bad++; $display("FAIL en_off_full got=%b want=0", tx_full); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_off_busy got=%b want=0", busy); end
      enable = 1'b1;
      tick();
      total++; if (tx_full !== 1'b1) begin bad++; $display("FAIL en_on_grant got=%b want=1", tx_full); end
      enable = 1'b0;
      pull_frame(1'b0, 16'd0, 1'b0);
      repeat (6) tick();
      total++; if (tx_full !== 1'b0) begin bad++; $display("FAIL en_drop_full got=%b want=0", tx_full); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_drop_busy got=%b want=0", busy); end
      total++; if (seq !== 16'd1) begin bad++; $display("FAIL en_drop_seq got=%0d want=1", seq); end
      src0_afull = 1'b0;
      src1_afull = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_gaps();
      test_overrun();
      test_reset_mid_frame();
      test_seq_wrap();
      test_enable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
